// File: rtl/ur408_cr_pkg.sv
// Shared constants for the UR408 control-register / PC unit: CR map, STATUS bits, FSM encoding.
package ur408_cr_pkg;

  localparam int unsigned XLEN     = 16;
  localparam int unsigned NIRQ     = 4;
  localparam int unsigned CR_SEL_W = 3;

  // Control-register indices as seen on selector
  localparam logic [CR_SEL_W-1:0] CR_PC     = 3'd0;
  localparam logic [CR_SEL_W-1:0] CR_EPC    = 3'd1;
  localparam logic [CR_SEL_W-1:0] CR_STATUS = 3'd2;
  localparam logic [CR_SEL_W-1:0] CR_IE     = 3'd3;
  localparam logic [CR_SEL_W-1:0] CR_IP     = 3'd4;
  localparam logic [CR_SEL_W-1:0] CR_IVEC   = 3'd5;
  localparam logic [CR_SEL_W-1:0] CR_SCR0   = 3'd6;
  localparam logic [CR_SEL_W-1:0] CR_SCR1   = 3'd7;

  // STATUS bit positions
  localparam int unsigned ST_GIE  = 0;
  localparam int unsigned ST_PGIE = 1;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } main_state_e;

  // Vector address for interrupt n: two words per vector slot
  function automatic logic [XLEN-1:0] irq_vector(input logic [XLEN-1:0] ivec,
                                                 input logic [1:0]      n);
    return ivec + {13'd0, n, 1'b0};
  endfunction

endpackage

// File: rtl/ur408_cr_irq.sv
// Interrupt front end: synchronises the request lines, detects rising edges into
// the pending register, and picks the lowest-numbered enabled pending line.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   i_int          raw request lines (level)
//   i_ie, i_gie    enable mask and global enable
//   i_stall        memory stall; no entry while set
//   i_ip_wr        software write to IP this cycle (already stall-gated)
//   i_ip_wdata     write-1-to-clear mask
//   o_irq_c        interrupt entry this cycle (combinational)
//   o_irq_n_c      index of the line being taken (combinational)
//   o_ip           pending register
module ur408_cr_irq
  import ur408_cr_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [NIRQ-1:0] i_int,
  input  logic [NIRQ-1:0] i_ie,
  input  logic            i_gie,
  input  logic            i_stall,
  input  logic            i_ip_wr,
  input  logic [NIRQ-1:0] i_ip_wdata,
  output logic            o_irq_c,
  output logic [1:0]      o_irq_n_c,
  output logic [NIRQ-1:0] o_ip
);

  logic [NIRQ-1:0] r_int_q;
  logic [NIRQ-1:0] r_int_d;
  logic [NIRQ-1:0] r_ip;
  logic [NIRQ-1:0] w_rise;
  logic [NIRQ-1:0] w_pend;
  logic [NIRQ-1:0] w_clr;
  logic [1:0]      w_n;
  logic            w_irq;

  assign w_rise = r_int_q & ~r_int_d;
  assign w_pend = r_ip & i_ie;
  assign w_irq  = i_gie & (|w_pend) & ~i_stall;

  // Priority encoder: int0 wins
  always_comb begin
    w_n = 2'd3;
    if (w_pend[0])      w_n = 2'd0;
    else if (w_pend[1]) w_n = 2'd1;
    else if (w_pend[2]) w_n = 2'd2;
  end

  // Entry clears the taken bit and masks any simultaneous software clear
  always_comb begin
    w_clr = '0;
    if (w_irq)        w_clr = 4'(1) << w_n;
    else if (i_ip_wr) w_clr = i_ip_wdata;
  end

  // Sync flop, edge history and pending bits; a new edge beats a clear
  always_ff @(posedge clk) begin
    if (rst) begin
      r_int_q <= '0;
      r_int_d <= '0;
      r_ip    <= '0;
    end else begin
      r_int_q <= i_int;
      r_int_d <= r_int_q;
      r_ip    <= (r_ip & ~w_clr) | w_rise;
    end
  end

  assign o_irq_c   = w_irq;
  assign o_irq_n_c = w_n;
  assign o_ip      = r_ip;

endmodule

// File: rtl/ur408_cr.sv
// UR408 control-register / program-counter unit: next-fetch-address mux, PC,
// EPC, STATUS, IE, IP, IVEC and scratch CRs, plus the RUN/MEM_WAIT state flop.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   pc_next                   next fetch address (combinational)
//   branch_offset             signed PC-relative branch offset
//   r6_r7_data                jump target / apc offset / CR write data
//   cr_data                   CR[selector] read data (combinational)
//   int0..int3                interrupt request lines
//   mem_read/mem_write/mem_ok data-memory handshake
//   branch, bra, jmp, apc, ret, cr_write, selector   decoder strobes
//   main_state                0 = RUN, 1 = MEM_WAIT (registered)
module ur408_cr
  import ur408_cr_pkg::*;
#(
  parameter logic [15:0] RST_PC   = 16'h0000,
  parameter logic [15:0] RST_IVEC = 16'h0010
) (
  input  logic                clk,
  input  logic                rst,
  output logic [XLEN-1:0]     pc_next,
  input  logic [XLEN-1:0]     branch_offset,
  input  logic [XLEN-1:0]     r6_r7_data,
  output logic [XLEN-1:0]     cr_data,
  input  logic                int0,
  input  logic                int1,
  input  logic                int2,
  input  logic                int3,
  input  logic                mem_read,
  input  logic                mem_write,
  input  logic                mem_ok,
  input  logic                branch,
  input  logic [CR_SEL_W-1:0] selector,
  input  logic                cr_write,
  input  logic                ret,
  input  logic                apc,
  input  logic                jmp,
  input  logic                bra,
  output logic                main_state
);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_epc;
  logic            r_gie;
  logic            r_pgie;
  logic [NIRQ-1:0] r_ie;
  logic [XLEN-1:0] r_ivec;
  logic [XLEN-1:0] r_scr0;
  logic [XLEN-1:0] r_scr1;
  main_state_e     r_state;
  main_state_e     w_state_next;

  logic            w_stall;
  logic            w_cr_we;
  logic            w_ret_take;
  logic            w_irq;
  logic [1:0]      w_irq_n;
  logic [NIRQ-1:0] w_ip;
  logic [XLEN-1:0] w_pc_seq;

  assign w_stall    = (mem_read | mem_write) & ~mem_ok;
  assign w_cr_we    = cr_write & ~w_stall;
  assign w_ret_take = ret & ~w_stall & ~w_irq;

  ur408_cr_irq u_irq (
    .clk        (clk),
    .rst        (rst),
    .i_int      ({int3, int2, int1, int0}),
    .i_ie       (r_ie),
    .i_gie      (r_gie),
    .i_stall    (w_stall),
    .i_ip_wr    (w_cr_we && (selector == CR_IP)),
    .i_ip_wdata (r6_r7_data[NIRQ-1:0]),
    .o_irq_c    (w_irq),
    .o_irq_n_c  (w_irq_n),
    .o_ip       (w_ip)
  );

  // Program-flow target ignoring interrupts; also the EPC saved on entry
  always_comb begin
    w_pc_seq = r_pc + 16'd1;
    if (ret)                 w_pc_seq = r_epc;
    else if (jmp)            w_pc_seq = r6_r7_data;
    else if (apc)            w_pc_seq = r_pc + r6_r7_data;
    else if (bra && branch)  w_pc_seq = r_pc + branch_offset;
  end

  always_comb begin
    pc_next = w_pc_seq;
    if (rst)          pc_next = RST_PC;
    else if (w_stall) pc_next = r_pc;
    else if (w_irq)   pc_next = irq_vector(r_ivec, w_irq_n);
  end

  // Main state: next-state logic
  always_comb begin
    w_state_next = RUN;
    if (w_stall) w_state_next = MEM_WAIT;
  end

  // Main state: register
  always_ff @(posedge clk) begin
    if (rst) r_state <= RUN;
    else     r_state <= w_state_next;
  end

  assign main_state = r_state;

  // CR file; interrupt entry takes precedence over software writes to EPC/STATUS
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc   <= RST_PC;
      r_epc  <= '0;
      r_gie  <= 1'b0;
      r_pgie <= 1'b0;
      r_ie   <= '0;
      r_ivec <= RST_IVEC;
      r_scr0 <= '0;
      r_scr1 <= '0;
    end else begin
      r_pc <= pc_next;
      if (w_irq) begin
        r_epc  <= w_pc_seq;
        r_pgie <= r_gie;
        r_gie  <= 1'b0;
      end else begin
        if (w_cr_we && (selector == CR_EPC)) r_epc <= r6_r7_data;
        if (w_cr_we && (selector == CR_STATUS)) begin
          r_gie  <= r6_r7_data[ST_GIE];
          r_pgie <= r6_r7_data[ST_PGIE];
        end
        if (w_ret_take) r_gie <= r_pgie;
      end
      if (w_cr_we) begin
        case (selector)
          CR_IE:   r_ie   <= r6_r7_data[NIRQ-1:0];
          CR_IVEC: r_ivec <= r6_r7_data;
          CR_SCR0: r_scr0 <= r6_r7_data;
          CR_SCR1: r_scr1 <= r6_r7_data;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    cr_data = '0;
    case (selector)
      CR_PC:     cr_data = r_pc;
      CR_EPC:    cr_data = r_epc;
      CR_STATUS: cr_data = {14'd0, r_pgie, r_gie};
      CR_IE:     cr_data = {12'd0, r_ie};
      CR_IP:     cr_data = {12'd0, w_ip};
      CR_IVEC:   cr_data = r_ivec;
      CR_SCR0:   cr_data = r_scr0;
      CR_SCR1:   cr_data = r_scr1;
      default:   cr_data = '0;
    endcase
  end

endmodule

// File: tb/tb_ur408_cr.sv
// Directed, table-driven bench for ur408_cr.
module tb_ur408_cr;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pc_next;
  logic [15:0] branch_offset;
  logic [15:0] r6_r7_data;
  logic [15:0] cr_data;
  logic [3:0]  ints;
  logic        mem_read, mem_write, mem_ok;
  logic        branch, cr_write, ret, apc, jmp, bra;
  logic [2:0]  selector;
  logic        main_state;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  ur408_cr dut (
    .clk           (clk),
    .rst           (rst),
    .pc_next       (pc_next),
    .branch_offset (branch_offset),
    .r6_r7_data    (r6_r7_data),
    .cr_data       (cr_data),
    .int0          (ints[0]),
    .int1          (ints[1]),
    .int2          (ints[2]),
    .int3          (ints[3]),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_ok        (mem_ok),
    .branch        (branch),
    .selector      (selector),
    .cr_write      (cr_write),
    .ret           (ret),
    .apc           (apc),
    .jmp           (jmp),
    .bra           (bra),
    .main_state    (main_state)
  );

  // ctl = {cr_write, ret, jmp, apc, bra, branch}; mem = {mem_read, mem_write, mem_ok}
  localparam logic [5:0] CW = 6'b100000, RT = 6'b010000, JP = 6'b001000;
  localparam logic [5:0] AP = 6'b000100, BR = 6'b000010, BT = 6'b000001;
  localparam logic [2:0] MR = 3'b100, MW = 3'b010, MO = 3'b001;

  typedef struct {
    logic        rst;
    logic [5:0]  ctl;
    logic [15:0] data;
    logic [15:0] off;
    logic [2:0]  sel;
    logic [3:0]  ints;
    logic [2:0]  mem;
    logic [15:0] exp_pc;
    logic        exp_ms;
    logic        chk_cr;
    logic [15:0] exp_cr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic [5:0] c, input logic [15:0] d,
                              input logic [15:0] o, input logic [2:0] s, input logic [3:0] ir,
                              input logic [2:0] m, input logic [15:0] epc, input logic ems,
                              input logic ccr, input logic [15:0] ecr);
    vec_t v;
    v.rst = r; v.ctl = c; v.data = d; v.off = o; v.sel = s; v.ints = ir; v.mem = m;
    v.exp_pc = epc; v.exp_ms = ems; v.chk_cr = ccr; v.exp_cr = ecr;
    return v;
  endfunction

  task automatic idle();
    rst = 1'b0; branch_offset = '0; r6_r7_data = '0; ints = '0;
    mem_read = 1'b0; mem_write = 1'b0; mem_ok = 1'b0;
    branch = 1'b0; cr_write = 1'b0; ret = 1'b0; apc = 1'b0; jmp = 1'b0; bra = 1'b0;
    selector = '0;
  endtask

  task automatic apply(input vec_t v);
    rst = v.rst;
    {cr_write, ret, jmp, apc, bra, branch} = v.ctl;
    r6_r7_data = v.data; branch_offset = v.off; selector = v.sel; ints = v.ints;
    {mem_read, mem_write, mem_ok} = v.mem;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic check_cycle(input string name, input logic [15:0] epc, input logic ems);
    check({name, " pc_next"}, pc_next, epc);
    check({name, " main_state"}, 16'(main_state), 16'(ems));
  endtask

  initial begin
    idle();
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Reset, free run, branches, jumps, wrap, stall, CR writes, interrupt round trip
    tbl.push_back(mk(1, 0,       16'h0000, 16'h0000, 3'd5, 4'h0, 0,     16'h0000, 0, 1, 16'h0010));
    tbl.push_back(mk(0, 0,       16'h0000, 16'h0000, 3'd0, 4'h0, 0,     16'h0001, 0, 1, 16'h0000));
    tbl.push_back(mk(0, 0,       16'h0000, 16'h0000, 3'd0, 4'h0, 0,     16'h0002, 0, 0, 16'h0000));
    tbl.push_back(mk(0, 0,       16'h0000, 16'h0000, 3'd0, 4'h0, 0,     16'h0003, 0, 0, 16'h0000));
    tbl.push_back(mk(0, JP,      16'h0010, 16'h0000, 3'd0, 4'h0, 0,     16'h0010, 0, 0, 16'h0000));
    tbl.push_back(mk(0, BR|BT,   16'h0000, 16'hFFFE, 3'd0, 4'h0, 0,     16'h000E, 0, 1, 16'h0010));
    tbl.push_back(mk(0, JP,      16'h0010, 16'h0000, 3'd0, 4'h0, 0,     16'h0010, 0, 0, 16'h0000));
    tbl.push_back(mk(0, BR,      16'h0000, 16'hFFFE, 3'd0, 4'h0, 0,     16'h0011, 0, 0, 16'h0000));
    tbl.push_back(mk(0, AP,      16'h0100, 16'h0000, 3'd0, 4'h0, 0,     16'h0111, 0, 0, 16'h0000));
    tbl.push_back(mk(0, JP|AP|BR|BT, 16'h0200, 16'h0005, 3'd0, 4'h0, 0, 16'h0200, 0, 0, 16'h0000));
    tbl.push_back(mk(0, JP,      16'hFFFF, 16'h0000, 3'd0, 4'h0, 0,     16'hFFFF, 0, 0, 16'h0000));
    tbl.push_back(mk(0, 0,       16'h0000, 16'h0000, 3'd0, 4'h0, 0,     16'h0000, 0, 1, 16'hFFFF));
    tbl.push_back(mk(0, 0,       16'h0000, 16'h0000, 3'd0, 4'h0, MR,    16'h0000, 0, 0, 16'h0000));
    tbl.push_back(mk(0, JP,      16'h1234, 16'h0000, 3'd0, 4'h0, MR,    16'h0000, 1, 0, 16'h0000));
    tbl.push_back(mk(0, 0,       16'h0000, 16'h0000, 3'd0, 4'h0, MR|MO, 16'h0001, 1, 0, 16'h0000));
    tbl.push_back(mk(0, 0,       16'h0000, 16'h0000, 3'd0, 4'h0, 0,     16'h0002, 0, 0, 16'h0000));
    tbl.push_back(mk(0, CW,      16'hBEEF, 16'h0000, 3'd6, 4'h0, 0,     16'h0003, 0, 1, 16'h0000));
    tbl.push_back(mk(0, 0,       16'h0000, 16'h0000, 3'd6, 4'h0, 0,     16'h0004, 0, 1, 16'hBEEF));
    tbl.push_back(mk(0, CW,      16'h5555, 16'h0000, 3'd0, 4'h0, 0,     16'h0005, 0, 1, 16'h0004));
    tbl.push_back(mk(0, 0,       16'h0000, 16'h0000, 3'd0, 4'h0, 0,     16'h0006, 0, 1, 16'h0005));
    tbl.push_back(mk(0, CW,      16'h1111, 16'h0000, 3'd7, 4'h0, MW,    16'h0006, 0, 0, 16'h0000));
    tbl.push_back(mk(0, 0,       16'h0000, 16'h0000, 3'd7, 4'h0, 0,     16'h0007, 1, 1, 16'h0000));
    tbl.push_back(mk(0, CW,      16'hFFFF, 16'h0000, 3'd4, 4'h0, 0,     16'h0008, 0, 1, 16'h0000));
    tbl.push_back(mk(0, CW,      16'hFFFF, 16'h0000, 3'd2, 4'h0, 0,     16'h0009, 0, 0, 16'h0000));
    tbl.push_back(mk(0, 0,       16'h0000, 16'h0000, 3'd2, 4'h0, 0,     16'h000A, 0, 1, 16'h0003));
    tbl.push_back(mk(0, CW,      16'h0006, 16'h0000, 3'd3, 4'h0, 0,     16'h000B, 0, 0, 16'h0000));
    tbl.push_back(mk(0, 0,       16'h0000, 16'h0000, 3'd3, 4'h0, 0,     16'h000C, 0, 1, 16'h0006));
    tbl.push_back(mk(0, JP,      16'h001F, 16'h0000, 3'd0, 4'h6, 0,     16'h001F, 0, 0, 16'h0000));
    tbl.push_back(mk(0, 0,       16'h0000, 16'h0000, 3'd0, 4'h0, 0,     16'h0020, 0, 0, 16'h0000));
    tbl.push_back(mk(0, 0,       16'h0000, 16'h0000, 3'd4, 4'h0, 0,     16'h0012, 0, 1, 16'h0006));
    tbl.push_back(mk(0, 0,       16'h0000, 16'h0000, 3'd1, 4'h0, 0,     16'h0013, 0, 1, 16'h0021));
    tbl.push_back(mk(0, 0,       16'h0000, 16'h0000, 3'd2, 4'h0, 0,     16'h0014, 0, 1, 16'h0002));
    tbl.push_back(mk(0, 0,       16'h0000, 16'h0000, 3'd4, 4'h0, 0,     16'h0015, 0, 1, 16'h0004));
    tbl.push_back(mk(0, RT,      16'h0000, 16'h0000, 3'd0, 4'h0, 0,     16'h0021, 0, 0, 16'h0000));
    tbl.push_back(mk(0, 0,       16'h0000, 16'h0000, 3'd2, 4'h0, 0,     16'h0014, 0, 1, 16'h0003));
    tbl.push_back(mk(0, 0,       16'h0000, 16'h0000, 3'd1, 4'h0, 0,     16'h0015, 0, 1, 16'h0022));
    tbl.push_back(mk(0, 0,       16'h0000, 16'h0000, 3'd4, 4'h0, 0,     16'h0016, 0, 1, 16'h0000));

    foreach (tbl[i]) begin
      @(negedge clk);
      apply(tbl[i]);
      #1;
      check_cycle($sformatf("v%0d", i), tbl[i].exp_pc, tbl[i].exp_ms);
      if (tbl[i].chk_cr) check($sformatf("v%0d cr_data", i), cr_data, tbl[i].exp_cr);
    end

    // Stall holds off a pending interrupt; entry then beats a STATUS write
    @(negedge clk); idle(); cr_write = 1; selector = 3'd3; r6_r7_data = 16'h000F;
    #1; check_cycle("h0", 16'h0017, 1'b0);
    @(negedge clk); idle(); cr_write = 1; selector = 3'd2; r6_r7_data = 16'h0001; ints = 4'h1;
    #1; check_cycle("h1", 16'h0018, 1'b0);
    @(negedge clk); idle(); mem_read = 1;
    #1; check_cycle("h2", 16'h0018, 1'b0);
    @(negedge clk); idle(); mem_read = 1; selector = 3'd4;
    #1; check_cycle("h3", 16'h0018, 1'b1);
    check("h3 ip pending", cr_data, 16'h0001);
    @(negedge clk); idle(); cr_write = 1; selector = 3'd2; r6_r7_data = 16'h0000;
    #1; check_cycle("h4 irq0", 16'h0010, 1'b1);
    @(negedge clk); idle(); selector = 3'd2;
    #1; check_cycle("h5", 16'h0011, 1'b0);
    check("h5 status", cr_data, 16'h0002);
    @(negedge clk); idle(); selector = 3'd1;
    #1; check_cycle("h6", 16'h0012, 1'b0);
    check("h6 epc", cr_data, 16'h0019);

    // New edge on int3 beats a simultaneous write-1-to-clear of IP
    @(negedge clk); idle(); ints = 4'h8;
    #1; check_cycle("h7", 16'h0013, 1'b0);
    @(negedge clk); idle(); cr_write = 1; selector = 3'd4; r6_r7_data = 16'h000F;
    #1; check_cycle("h8", 16'h0014, 1'b0);
    @(negedge clk); idle(); selector = 3'd4;
    #1; check_cycle("h9", 16'h0015, 1'b0);
    check("h9 ip set wins", cr_data, 16'h0008);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
